// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instmem AR and queues returned words for decode.
// Optional FETCH_SKID_EN: two-entry output FIFO for one instruction per cycle; default is one register.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INSTMEM_WORDSIZE
`define INSTMEM_WORDSIZE 32
`endif

module fetch_unit #(
    parameter int                ADDR_W   = `INSTMEM_ADDR_WIDTH,
    parameter int                WORD_W   = `INSTMEM_WORDSIZE,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [WORD_W-1:0] im_data,
    output logic              inst_valid,
    output logic [WORD_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              busy
);

`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   pc_p0;
    logic                vld_p1;
    logic [ADDR_W-1:0]   pend_pc_p1;
    logic [1:0]          occ_p2;
    logic                pop;
    logic                push;
    logic                room;
    logic                issue;
    logic [2:0]          inflight;

    assign pop      = inst_valid & inst_ready & ~redirect_valid;
    assign push     = vld_p1 & ~redirect_valid;
    assign inflight = {1'b0, occ_p2} + {2'b00, vld_p1};
    // occ + pending - pop < CAP, rearranged so nothing goes negative
    assign room     = inflight < (3'(CAP) + {2'b00, pop});
    assign issue    = (state_q == RUN) & ~halt & ~redirect_valid & room;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !halt)
                    state_d = RUN;
            end
            RUN: begin
                if (halt)
                    state_d = (vld_p1 && !redirect_valid) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (redirect_valid || !vld_p1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- p0: program counter / issue ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_p0      <= RESET_PC;
            vld_p1     <= 1'b0;
            pend_pc_p1 <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid)
                pc_p0 <= redirect_pc;
            else if (issue)
                pc_p0 <= pc_p0 + 1'b1;
            vld_p1 <= issue;
            if (issue)
                pend_pc_p1 <= pc_p0;
        end
    end

    // ---- p2: output queue, filled from the instmem word returned for pend_pc_p1 ----
`ifdef FETCH_SKID_EN
    logic [WORD_W-1:0] q_data_p2 [2];
    logic [ADDR_W-1:0] q_pc_p2   [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_p2       <= 2'd0;
            q_data_p2[0] <= '0;
            q_data_p2[1] <= '0;
            q_pc_p2[0]   <= '0;
            q_pc_p2[1]   <= '0;
        end else if (redirect_valid) begin
            occ_p2 <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_p2 == 2'd0) begin
                        q_data_p2[0] <= im_data;
                        q_pc_p2[0]   <= pend_pc_p1;
                    end else begin
                        q_data_p2[1] <= im_data;
                        q_pc_p2[1]   <= pend_pc_p1;
                    end
                    occ_p2 <= occ_p2 + 2'd1;
                end
                2'b01: begin
                    q_data_p2[0] <= q_data_p2[1];
                    q_pc_p2[0]   <= q_pc_p2[1];
                    occ_p2       <= occ_p2 - 2'd1;
                end
                2'b11: begin
                    if (occ_p2 == 2'd1) begin
                        q_data_p2[0] <= im_data;
                        q_pc_p2[0]   <= pend_pc_p1;
                    end else begin
                        q_data_p2[0] <= q_data_p2[1];
                        q_pc_p2[0]   <= q_pc_p2[1];
                        q_data_p2[1] <= im_data;
                        q_pc_p2[1]   <= pend_pc_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_data = q_data_p2[0];
    assign inst_pc   = q_pc_p2[0];
`else
    logic [WORD_W-1:0] q_data_p2;
    logic [ADDR_W-1:0] q_pc_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_p2    <= 2'd0;
            q_data_p2 <= '0;
            q_pc_p2   <= '0;
        end else if (redirect_valid) begin
            occ_p2 <= 2'd0;
        end else begin
            if (push) begin
                q_data_p2 <= im_data;
                q_pc_p2   <= pend_pc_p1;
                occ_p2    <= 2'd1;
            end else if (pop) begin
                occ_p2 <= 2'd0;
            end
        end
    end

    assign inst_data = q_data_p2;
    assign inst_pc   = q_pc_p2;
`endif

    assign im_addr    = pc_p0;
    assign inst_valid = (occ_p2 != 2'd0);
    assign busy       = (state_q == RUN) | vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: start-up vector table, scoreboarded streaming with stall, redirect,
// halt-with-pending, async reset and a 4-bit PC wrap on a second instance.
`timescale 1ns/1ps

module tb_fetch_unit;
    localparam int AW = 8;
    localparam int WW = 32;
`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] im_addr, inst_pc;
    logic [WW-1:0] im_data = '0;
    logic [WW-1:0] inst_data;
    logic          inst_valid, busy;

    fetch_unit #(.ADDR_W(AW), .WORD_W(WW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_addr(im_addr), .im_data(im_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .busy(busy)
    );

    always @(posedge clk) im_data <= 32'hA000_0000 + 32'(im_addr);

    logic        w_start = 1'b0, w_halt = 1'b0, w_redirect_valid = 1'b0, w_inst_ready = 1'b1;
    logic [3:0]  w_redirect_pc = '0;
    logic [3:0]  w_im_addr, w_inst_pc;
    logic [31:0] w_im_data = '0;
    logic [31:0] w_inst_data;
    logic        w_inst_valid, w_busy;

    fetch_unit #(.ADDR_W(4), .WORD_W(32), .RESET_PC(4'h0)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .halt(w_halt),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .im_addr(w_im_addr), .im_data(w_im_data),
        .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .inst_ready(w_inst_ready), .busy(w_busy)
    );

    always @(posedge clk) w_im_data <= 32'hA000_0000 + 32'(w_im_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected PCs in delivery order; every presented head is checked.
    logic [AW-1:0] exp_q[$];
    bit            mon_en = 1'b0;
    int            delivered = 0;

    always @(negedge clk) begin : mon
        logic [AW-1:0] lead;
        if (mon_en && !rst && !redirect_valid && inst_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", 64'(inst_pc), 64'hFFFF);
            end else begin
                check("sb_pc", 64'(inst_pc), 64'(exp_q[0]));
                check("sb_data", 64'(inst_data), 64'(32'hA000_0000 + 32'(exp_q[0])));
                lead = im_addr - inst_pc;
                check("sb_lead_le_cap", 64'(lead <= 8'(CAP)), 64'd1);
                if (inst_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    task automatic sb_load(input logic [AW-1:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
    endtask

    task automatic wait_delivered(input int target, input int budget);
        int n = 0;
        while (delivered < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_delivered", 64'(delivered >= target), 64'd1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        w_start = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
        delivered = 0;
    endtask

    typedef struct {
        logic          start;
        logic          halt;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic          exp_busy;
        logic [AW-1:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(logic s, logic h, logic v, logic [AW-1:0] pc, logic b, logic [AW-1:0] a);
        vec_t r;
        r.start = s; r.halt = h; r.exp_valid = v; r.exp_pc = pc; r.exp_busy = b; r.exp_addr = a;
        return r;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          vt[9];
        logic [AW-1:0] held_pc;
        logic [WW-1:0] held_data;
        logic [AW-1:0] lead;
        logic [3:0]    wexp[4];
        int            n;
        int            k;

        // start-up table: row0 start+halt together must stay idle
        vt[0] = mk(1, 1, 0, 8'h00, 0, 8'h00);
        vt[1] = mk(1, 0, 0, 8'h00, 0, 8'h00);
        vt[2] = mk(0, 0, 0, 8'h00, 1, 8'h00);
        vt[3] = mk(0, 0, 0, 8'h00, 1, 8'h01);
`ifdef FETCH_SKID_EN
        vt[4] = mk(0, 0, 1, 8'h00, 1, 8'h02);
        vt[5] = mk(0, 0, 1, 8'h01, 1, 8'h03);
        vt[6] = mk(0, 0, 1, 8'h02, 1, 8'h04);
        vt[7] = mk(0, 0, 1, 8'h03, 1, 8'h05);
        vt[8] = mk(0, 0, 1, 8'h04, 1, 8'h06);
`else
        vt[4] = mk(0, 0, 1, 8'h00, 1, 8'h01);
        vt[5] = mk(0, 0, 0, 8'h00, 1, 8'h02);
        vt[6] = mk(0, 0, 1, 8'h01, 1, 8'h02);
        vt[7] = mk(0, 0, 0, 8'h00, 1, 8'h03);
        vt[8] = mk(0, 0, 1, 8'h02, 1, 8'h03);
`endif

        do_reset();
        @(negedge clk);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_data", 64'(inst_data), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        check("rst_addr", 64'(im_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();

        inst_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start = vt[i].start;
            halt  = vt[i].halt;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(inst_valid), 64'(vt[i].exp_valid));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
            check($sformatf("vec%0d_addr", i), 64'(im_addr), 64'(vt[i].exp_addr));
            if (vt[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), 64'(inst_pc), 64'(vt[i].exp_pc));
                check($sformatf("vec%0d_data", i), 64'(inst_data),
                      64'(32'hA000_0000 + 32'(vt[i].exp_pc)));
            end
            tick();
        end
        start = 1'b0;
        halt  = 1'b0;

        // streaming with a stall, then redirect
        do_reset();
        sb_load(8'h00, 64);
        mon_en = 1'b1;
        inst_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_delivered(6, 60);

        inst_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", 64'(inst_valid), 64'd1);
        held_pc   = inst_pc;
        held_data = inst_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid_hold", 64'(inst_valid), 64'd1);
            check("stall_pc_hold", 64'(inst_pc), 64'(held_pc));
            check("stall_data_hold", 64'(inst_data), 64'(held_data));
        end
        lead = im_addr - inst_pc;
        check("stall_lead", 64'(lead), 64'(CAP));
        tick();
        inst_ready = 1'b1;
        wait_delivered(delivered + 8, 40);

        n = 0;
        while (!inst_valid && n < 6) begin
            tick();
            n++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        sb_load(8'h40, 16);
        @(negedge clk);
        check("redir_flush", 64'(inst_valid), 64'd0);
        check("redir_pc_loaded", 64'(im_addr), 64'h40);
        tick();
        @(negedge clk);
        check("redir_gap_valid", 64'(inst_valid), 64'd0);
        check("redir_issued", 64'(im_addr), 64'h41);
        tick();
        @(negedge clk);
        check("redir_first_valid", 64'(inst_valid), 64'd1);
        check("redir_first_pc", 64'(inst_pc), 64'h40);
        check("redir_first_data", 64'(inst_data), 64'hA000_0040);
        tick();
        wait_delivered(delivered + 6, 40);

        // halt while a fetch is in flight
        do_reset();
        sb_load(8'h00, 16);
        mon_en = 1'b1;
        inst_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        halt = 1'b1;
        @(negedge clk);
        check("halt_busy_pending", 64'(busy), 64'd1);
        tick();
        halt = 1'b0;
        @(negedge clk);
        check("halt_busy_landed", 64'(busy), 64'd0);
        check("halt_word_valid", 64'(inst_valid), 64'd1);
        check("halt_word_pc", 64'(inst_pc), 64'h00);
        tick();
        @(negedge clk);
        check("halt_idle_busy", 64'(busy), 64'd0);
        check("halt_idle_addr", 64'(im_addr), 64'h01);
        tick();
        inst_ready = 1'b1;
        tick();
        check("halt_delivered", 64'(delivered), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_delivered(3, 20);

        // async reset between edges mid-stream
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(inst_valid), 64'd0);
        check("arst_addr", 64'(im_addr), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_pc", 64'(inst_pc), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        delivered = 0;
        tick();
        sb_load(8'h00, 16);
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_delivered(3, 20);
        mon_en = 1'b0;

        // PC wrap on the 4-bit instance
        do_reset();
        wexp[0] = 4'hE; wexp[1] = 4'hF; wexp[2] = 4'h0; wexp[3] = 4'h1;
        w_redirect_valid = 1'b1;
        w_redirect_pc    = 4'hE;
        tick();
        w_redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_pc_loaded", 64'(w_im_addr), 64'hE);
        check("wrap_idle_busy", 64'(w_busy), 64'd0);
        tick();
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            @(negedge clk);
            if (w_inst_valid) begin
                check("wrap_pc", 64'(w_inst_pc), 64'(wexp[k]));
                check("wrap_data", 64'(w_inst_data), 64'(32'hA000_0000 + 32'(wexp[k])));
                k++;
            end
        end
        check("wrap_count", 64'(k), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
